// File: rtl/stopwatch_core.sv
// Stopwatch control FSM (STOP/RUN/CLEAR) with tick divider and
// hundredths/sec/min/hour counters wrapping at 23:59:59.99.
module stopwatch_core #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running,
    output logic       o_tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_run_q;
    logic          r_clr_q;
    logic          w_run_e;
    logic          w_clr_e;
    logic          w_tick;
    logic [DW-1:0] r_div;
    logic [6:0]    r_msec;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hour;

    assign w_run_e = btn_run & ~r_run_q;
    assign w_clr_e = btn_clear & ~r_clr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_q <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_run_q <= btn_run;
            r_clr_q <= btn_clear;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_next;
        end
    end

    // Clear outranks run when both edges land in STOP.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_STOP: begin
                if (w_clr_e) begin
                    w_next = ST_CLEAR;
                end else if (w_run_e) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_e) begin
                    w_next = ST_STOP;
                end
            end
            ST_CLEAR: begin
                w_next = ST_STOP;
            end
            default: begin
                w_next = ST_STOP;
            end
        endcase
    end

    assign w_tick = (r_state == ST_RUN) && (r_div == DIV_MAX);

    // Counters are only written on tick/clear so STOP holds them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_msec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_div  <= '0;
            r_msec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_tick) begin
                r_div <= '0;
                if (r_msec == 7'd99) begin
                    r_msec <= '0;
                    if (r_sec == 6'd59) begin
                        r_sec <= '0;
                        if (r_min == 6'd59) begin
                            r_min <= '0;
                            if (r_hour == 5'd23) begin
                                r_hour <= '0;
                            end else begin
                                r_hour <= r_hour + 5'd1;
                            end
                        end else begin
                            r_min <= r_min + 6'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end else begin
                    r_msec <= r_msec + 7'd1;
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign o_msec    = r_msec;
    assign o_sec     = r_sec;
    assign o_min     = r_min;
    assign o_hour    = r_hour;
    assign o_running = (r_state == ST_RUN);
    assign o_tick    = w_tick;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at DIV=10.
// Expected values are hand-derived cycle counts from the button edges.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_clear;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_running;
    logic       o_tick;

    int errors = 0;
    int checks = 0;

    stopwatch_core #(
        .CLK_HZ (10),
        .TICK_HZ(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_clear(btn_clear),
        .o_msec   (o_msec),
        .o_sec    (o_sec),
        .o_min    (o_min),
        .o_hour   (o_hour),
        .o_running(o_running),
        .o_tick   (o_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_run();
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
    endtask

    task automatic press_clr();
        btn_clear = 1'b1;
        @(negedge clk);
        btn_clear = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_msec"}, int'(o_msec), 0);
        check({tag, "_sec"}, int'(o_sec), 0);
        check({tag, "_min"}, int'(o_min), 0);
        check({tag, "_hour"}, int'(o_hour), 0);
        check({tag, "_run"}, int'(o_running), 0);
        check({tag, "_tick"}, int'(o_tick), 0);
    endtask

    initial begin
        rst       = 1'b1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step(1);

        // 1: start, first tick after DIV cycles
        press_run();
        check("t1_run", int'(o_running), 1);
        check("t1_msec0", int'(o_msec), 0);
        step(9);
        check("t1_tick", int'(o_tick), 1);
        check("t1_msec_pre", int'(o_msec), 0);
        step(1);
        check("t1_msec1", int'(o_msec), 1);
        check("t1_tick_lo", int'(o_tick), 0);
        step(90);
        check("t1_msec10", int'(o_msec), 10);
        press_run();
        check("t1_stop", int'(o_running), 0);
        step(1);

        // 2: held button gives one edge
        btn_run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("t2_held", int'(o_running), 1);
        end
        btn_run = 1'b0;
        step(5);
        check("t2_after", int'(o_running), 1);
        press_run();
        check("t2_stop", int'(o_running), 0);
        step(1);
        press_clr();
        step(1);
        check("t2_clr_msec", int'(o_msec), 0);
        step(1);

        // 3: stop/resume keeps divider phase
        press_run();
        step(34);
        press_run();
        check("t3_stop", int'(o_running), 0);
        check("t3_msec3", int'(o_msec), 3);
        step(100);
        check("t3_hold_msec", int'(o_msec), 3);
        check("t3_hold_run", int'(o_running), 0);
        press_run();
        check("t3_resume", int'(o_running), 1);
        step(4);
        check("t3_msec_pre", int'(o_msec), 3);
        step(1);
        check("t3_msec4", int'(o_msec), 4);

        // 4: simultaneous run+clear in STOP -> clear wins
        step(30);
        check("t4_msec7_run", int'(o_msec), 7);
        press_run();
        check("t4_stop", int'(o_running), 0);
        check("t4_msec7", int'(o_msec), 7);
        step(1);
        btn_run   = 1'b1;
        btn_clear = 1'b1;
        step(1);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        check("t4_in_clear_run", int'(o_running), 0);
        check("t4_in_clear_msec", int'(o_msec), 7);
        step(1);
        check("t4_clr_msec", int'(o_msec), 0);
        check("t4_clr_sec", int'(o_sec), 0);
        check("t4_clr_run", int'(o_running), 0);
        step(20);
        check("t4_idle_msec", int'(o_msec), 0);
        check("t4_idle_run", int'(o_running), 0);

        // 5: clear ignored in RUN
        press_run();
        check("t5_run", int'(o_running), 1);
        step(14);
        check("t5_msec1", int'(o_msec), 1);
        press_clr();
        check("t5_clr_run", int'(o_running), 1);
        check("t5_clr_msec", int'(o_msec), 1);
        step(5);
        check("t5_msec2", int'(o_msec), 2);
        check("t5_run2", int'(o_running), 1);

        // 6: full wrap from 23:59:59.99, then async reset
        press_run();
        check("t6_stop", int'(o_running), 0);
        step(1);
        press_clr();
        step(1);
        check("t6_clr_msec", int'(o_msec), 0);
        force dut.r_msec = 7'd99;
        force dut.r_sec  = 6'd59;
        force dut.r_min  = 6'd59;
        force dut.r_hour = 5'd23;
        step(1);
        release dut.r_msec;
        release dut.r_sec;
        release dut.r_min;
        release dut.r_hour;
        step(1);
        check("t6_load_hour", int'(o_hour), 23);
        press_run();
        check("t6_run", int'(o_running), 1);
        step(9);
        check("t6_tick", int'(o_tick), 1);
        check("t6_pre_msec", int'(o_msec), 99);
        check("t6_pre_sec", int'(o_sec), 59);
        check("t6_pre_min", int'(o_min), 59);
        check("t6_pre_hour", int'(o_hour), 23);
        step(1);
        check("t6_wrap_msec", int'(o_msec), 0);
        check("t6_wrap_sec", int'(o_sec), 0);
        check("t6_wrap_min", int'(o_min), 0);
        check("t6_wrap_hour", int'(o_hour), 0);
        check("t6_wrap_run", int'(o_running), 1);
        step(10);
        check("t6_msec1", int'(o_msec), 1);
        step(3);
        rst = 1'b1;
        #1;
        check_zero("t6_rst");
        step(2);
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
